// File: rtl/rs_fp_multi.sv
// FP reservation station: dual-lane dispatch, multi-channel CDB wakeup, oldest-ready issue via age matrix.
// Optional macro RS_DISP_BYPASS_EN lets dispatching lanes capture a same-cycle CDB broadcast.
module rs_fp_multi #(
  parameter int ENTRIES = 8,
  parameter int DW      = 32,
  parameter int TW      = 5,
  parameter int OPW     = 2,
  parameter int NCDB    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               disp_valid,
  input  logic [2*OPW-1:0]         disp_op,
  input  logic [9:0]               disp_dst,
  input  logic [2*TW-1:0]          disp_dtag,
  input  logic [1:0]               disp_v1,
  input  logic [1:0]               disp_v2,
  input  logic [2*TW-1:0]          disp_t1,
  input  logic [2*TW-1:0]          disp_t2,
  input  logic [2*DW-1:0]          disp_d1,
  input  logic [2*DW-1:0]          disp_d2,
  output logic                     disp_ready,
  input  logic [NCDB-1:0]          cdb_valid,
  input  logic [NCDB*TW-1:0]       cdb_tag,
  input  logic [NCDB*DW-1:0]       cdb_val,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OPW-1:0]           iss_op,
  output logic [4:0]               iss_dst,
  output logic [TW-1:0]            iss_dtag,
  output logic [DW-1:0]            iss_val1,
  output logic [DW-1:0]            iss_val2,
  output logic [$clog2(ENTRIES):0] free_cnt
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = IW + 1;

  // Lowest set bit as {found, index}.
  function automatic logic [IW:0] first_set(input logic [ENTRIES-1:0] vec);
    logic [IW:0] res;
    res = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) res = {1'b1, IW'(i)};
    end
    return res;
  endfunction

  // CDB tag match as {hit, value}; the lowest matching channel wins.
  function automatic logic [DW:0] cdb_lookup(input logic [TW-1:0] tag,
                                             input logic [NCDB-1:0] vld,
                                             input logic [NCDB*TW-1:0] tags,
                                             input logic [NCDB*DW-1:0] vals);
    logic [DW:0] res;
    res = '0;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*TW +: TW] == tag)) res = {1'b1, vals[k*DW +: DW]};
    end
    return res;
  endfunction

  logic [ENTRIES-1:0] busy_r, v1_r, v2_r;
  logic [OPW-1:0]     op_r   [ENTRIES];
  logic [4:0]         dst_r  [ENTRIES];
  logic [TW-1:0]      dtag_r [ENTRIES];
  logic [TW-1:0]      t1_r   [ENTRIES];
  logic [TW-1:0]      t2_r   [ENTRIES];
  logic [DW-1:0]      d1_r   [ENTRIES];
  logic [DW-1:0]      d2_r   [ENTRIES];
  logic [ENTRIES-1:0] age_r  [ENTRIES];
  logic [ENTRIES-1:0] age_s  [ENTRIES];
  logic [CW-1:0]      free_cnt_r;
  logic               hold_r;
  logic [IW-1:0]      hold_idx_r;

  logic [ENTRIES-1:0] free_s, mask_s, new_s, kill_s, ready_s, oldest_s;
  logic [IW:0]        f0_s, f1_s, pick_s;
  logic [IW-1:0]      a0_s, a1_s, sel_idx_s;
  logic [1:0]         acc_s;
  logic               sel_valid_s, fire_s;
  logic [1:0]         ln_v1_s, ln_v2_s;
  logic [DW-1:0]      ln_d1_s [2];
  logic [DW-1:0]      ln_d2_s [2];
  logic [DW:0]        wk1_s [ENTRIES];
  logic [DW:0]        wk2_s [ENTRIES];

  assign disp_ready = (free_cnt_r >= CW'(2));
  assign free_cnt   = free_cnt_r;
  assign iss_valid  = sel_valid_s;
  assign iss_op     = op_r[sel_idx_s];
  assign iss_dst    = dst_r[sel_idx_s];
  assign iss_dtag   = dtag_r[sel_idx_s];
  assign iss_val1   = d1_r[sel_idx_s];
  assign iss_val2   = d2_r[sel_idx_s];

  // Operand values as written by each dispatch lane.
  always_comb begin
`ifdef RS_DISP_BYPASS_EN
    logic [DW:0] bp1, bp2;
`endif
    for (int n = 0; n < 2; n++) begin
      ln_v1_s[n] = disp_v1[n];
      ln_v2_s[n] = disp_v2[n];
      ln_d1_s[n] = disp_d1[n*DW +: DW];
      ln_d2_s[n] = disp_d2[n*DW +: DW];
`ifdef RS_DISP_BYPASS_EN
      bp1 = cdb_lookup(disp_t1[n*TW +: TW], cdb_valid, cdb_tag, cdb_val);
      bp2 = cdb_lookup(disp_t2[n*TW +: TW], cdb_valid, cdb_tag, cdb_val);
      if (!disp_v1[n] && bp1[DW]) begin
        ln_v1_s[n] = 1'b1;
        ln_d1_s[n] = bp1[DW-1:0];
      end else begin
        ln_v1_s[n] = disp_v1[n];
        ln_d1_s[n] = disp_d1[n*DW +: DW];
      end
      if (!disp_v2[n] && bp2[DW]) begin
        ln_v2_s[n] = 1'b1;
        ln_d2_s[n] = bp2[DW-1:0];
      end else begin
        ln_v2_s[n] = disp_v2[n];
        ln_d2_s[n] = disp_d2[n*DW +: DW];
      end
`endif
    end
  end

  // Per-entry CDB match for waiting operands.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      wk1_s[i] = cdb_lookup(t1_r[i], cdb_valid, cdb_tag, cdb_val);
      wk2_s[i] = cdb_lookup(t2_r[i], cdb_valid, cdb_tag, cdb_val);
    end
  end

  // Slot allocation; only entries free at the start of the cycle are used.
  always_comb begin
    free_s = ~busy_r;
    f0_s   = first_set(free_s);
    for (int i = 0; i < ENTRIES; i++) begin
      mask_s[i] = free_s[i] & (f0_s[IW-1:0] != IW'(i));
    end
    f1_s     = first_set(mask_s);
    a0_s     = f0_s[IW-1:0];
    acc_s[0] = disp_valid[0] & disp_ready & f0_s[IW];
    if (acc_s[0]) begin
      a1_s     = f1_s[IW-1:0];
      acc_s[1] = disp_valid[1] & disp_ready & f1_s[IW];
    end else begin
      a1_s     = f0_s[IW-1:0];
      acc_s[1] = disp_valid[1] & disp_ready & f0_s[IW];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      new_s[i] = (acc_s[0] & (a0_s == IW'(i))) | (acc_s[1] & (a1_s == IW'(i)));
    end
  end

  // Oldest-ready select; a presented but unaccepted entry stays locked.
  always_comb begin
    logic blocked;
    for (int i = 0; i < ENTRIES; i++) begin
      ready_s[i] = busy_r[i] & v1_r[i] & v2_r[i];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < ENTRIES; j++) begin
        blocked = blocked | (ready_s[j] & age_r[j][i]);
      end
      oldest_s[i] = ready_s[i] & ~blocked;
    end
    pick_s = first_set(oldest_s);
    if (hold_r) begin
      sel_idx_s   = hold_idx_r;
      sel_valid_s = 1'b1;
    end else begin
      sel_idx_s   = pick_s[IW-1:0];
      sel_valid_s = pick_s[IW];
    end
    fire_s = sel_valid_s & iss_ready;
    for (int i = 0; i < ENTRIES; i++) begin
      kill_s[i] = fire_s & (sel_idx_s == IW'(i));
    end
  end

  // Next age matrix: issued rows/columns clear, new entries are youngest.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        if (kill_s[i] || kill_s[j]) begin
          age_s[i][j] = 1'b0;
        end else if (new_s[i]) begin
          age_s[i][j] = acc_s[0] & acc_s[1] & (a0_s == IW'(i)) & (a1_s == IW'(j));
        end else if (new_s[j]) begin
          age_s[i][j] = busy_r[i];
        end else begin
          age_s[i][j] = age_r[i][j];
        end
      end
    end
  end

  // Control state: occupancy, ordering, free count and issue lock.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy_r     <= '0;
      free_cnt_r <= CW'(ENTRIES);
      hold_r     <= 1'b0;
      hold_idx_r <= '0;
      for (int i = 0; i < ENTRIES; i++) age_r[i] <= '0;
    end else begin
      busy_r     <= (busy_r | new_s) & ~kill_s;
      free_cnt_r <= free_cnt_r + CW'(fire_s) - CW'(acc_s[0]) - CW'(acc_s[1]);
      hold_r     <= sel_valid_s & ~iss_ready;
      hold_idx_r <= sel_idx_s;
      for (int i = 0; i < ENTRIES; i++) age_r[i] <= age_s[i];
    end
  end

  // Entry payload: dispatch writes, otherwise CDB captures for waiting operands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (acc_s[0] && (a0_s == IW'(i))) begin
        op_r[i]   <= disp_op[0 +: OPW];
        dst_r[i]  <= disp_dst[4:0];
        dtag_r[i] <= disp_dtag[0 +: TW];
        t1_r[i]   <= disp_t1[0 +: TW];
        t2_r[i]   <= disp_t2[0 +: TW];
        v1_r[i]   <= ln_v1_s[0];
        v2_r[i]   <= ln_v2_s[0];
        d1_r[i]   <= ln_d1_s[0];
        d2_r[i]   <= ln_d2_s[0];
      end else if (acc_s[1] && (a1_s == IW'(i))) begin
        op_r[i]   <= disp_op[OPW +: OPW];
        dst_r[i]  <= disp_dst[9:5];
        dtag_r[i] <= disp_dtag[TW +: TW];
        t1_r[i]   <= disp_t1[TW +: TW];
        t2_r[i]   <= disp_t2[TW +: TW];
        v1_r[i]   <= ln_v1_s[1];
        v2_r[i]   <= ln_v2_s[1];
        d1_r[i]   <= ln_d1_s[1];
        d2_r[i]   <= ln_d2_s[1];
      end else begin
        if (busy_r[i] && !v1_r[i] && wk1_s[i][DW]) begin
          v1_r[i] <= 1'b1;
          d1_r[i] <= wk1_s[i][DW-1:0];
        end
        if (busy_r[i] && !v2_r[i] && wk2_s[i][DW]) begin
          v2_r[i] <= 1'b1;
          d2_r[i] <= wk2_s[i][DW-1:0];
        end
      end
    end
  end

endmodule

// File: doc/rs_fp_multi.md
Name: rs_fp_multi

Overview:
Parametrised FP reservation station. Sits between rename/dispatch and the FP execution unit. Accepts up to two renamed instructions per cycle and holds them until both operands are valid. Captures operand values from NCDB common-data-bus channels and issues the oldest ready entry to the FU over a valid/ready handshake.

Parameters:
ENTRIES, 8, number of station entries (>=2)
DW, 32, operand/result data width
TW, 5, physical tag width
OPW, 2, opcode width
NCDB, 2, number of CDB broadcast channels

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
flush  input  1  synchronous squash of all entries
disp_valid  input  2  per-lane dispatch request; lane 0 is older than lane 1
disp_op  input  2*OPW  per-lane opcode (lane n at [n*OPW +: OPW])
disp_dst  input  2*5  per-lane architectural destination
disp_dtag  input  2*TW  per-lane destination tag
disp_v1, disp_v2  input  2  per-lane source-valid flags
disp_t1, disp_t2  input  2*TW  per-lane source tags
disp_d1, disp_d2  input  2*DW  per-lane source values
disp_ready  output  1  station can accept two instructions this cycle
cdb_valid  input  NCDB  broadcast valid per channel
cdb_tag  input  NCDB*TW  broadcast tags
cdb_val  input  NCDB*DW  broadcast values
iss_valid  output  1  a ready entry is presented
iss_ready  input  1  FU accepts the presented entry
iss_op, iss_dst, iss_dtag  output  OPW/5/TW  issued instruction fields
iss_val1, iss_val2  output  DW  issued operands
free_cnt  output  $clog2(ENTRIES)+1  number of free entries

Behaviour:
- Entry state: busy, op, dst, dtag, v1/t1/d1, v2/t2/d2, plus an ENTRIES x ENTRIES age matrix (bit[i][j]=1 means i is older than j).
- Reset or flush: all busy=0, age matrix cleared. On the following cycle iss_valid=0, free_cnt=ENTRIES, disp_ready=1. flush has priority over dispatch, issue and wakeup in the same cycle.
- disp_ready = (free_cnt >= 2). It is combinational from registered state only.
- Dispatch: a lane is accepted when disp_valid[n] & disp_ready. Lane 0 takes the lowest-index free entry. Lane 1 takes the next-lowest, or the lowest when lane 0 is idle. Accepted entries become busy at the edge. Each new entry is younger than every existing entry; lane 1 is younger than lane 0.
- Wakeup: for each busy entry with v1=0, if any channel k has cdb_valid[k] & cdb_tag[k]==t1, load d1 from that channel and set v1=1. The same rule applies to operand 2. If several channels match, the lowest k wins. Wakeup becomes visible the next cycle.
- Select: an entry is ready when busy & v1 & v2. iss_valid = any ready entry. Payload comes from the oldest ready entry via the age matrix. Select is combinational from registered state, so latency from the last wakeup edge to iss_valid is 0 cycles.
- Issue: on iss_valid & iss_ready the selected entry gets busy=0 at the edge and its age row/column is cleared. An entry freed this cycle is not reallocated until the next cycle. Payload stays stable while iss_valid & ~iss_ready.
- Simultaneous dispatch, issue and wakeup in one cycle all take effect. free_cnt' = free_cnt - accepted + issued.
- No stall deadlock: dispatch never overwrites a busy entry. Requests with disp_ready=0 are dropped, and upstream must hold them.

Optional Feature:
Macro RS_DISP_BYPASS_EN.
- Defined: each dispatching lane's unready source tags are also compared against the current-cycle CDB. On a match the entry is written with v=1 and the CDB value, so a same-cycle broadcast is never missed.
- Undefined: entries are written exactly as presented. Upstream rename must forward any same-cycle CDB result into disp_v/disp_d; otherwise the entry waits forever.

Test Plan:
- Reset, then two lanes with all operands valid (d1=3.0 bits 0x40400000) and iss_ready=1 -> lane 0 issues the next cycle, lane 1 the cycle after; free_cnt returns to 8.
- Dispatch entry waiting on t1=7, then cdb_valid[1]=1 with tag 7 and val 0x3F800000 -> iss_valid=1 the next cycle with iss_val1=0x3F800000.
- Fill 7 entries -> disp_ready=0 and further dispatch is ignored. Issue one entry -> disp_ready=1 the next cycle.
- Three entries A,B,C dispatched in that order, with C ready first and then A and C ready together -> issue order C, A; B follows after its wakeup.
- Hold iss_ready=0 for 3 cycles with a ready entry -> iss_valid stays 1 with stable payload and no entry is freed.
- Dispatch with t2=9 and cdb tag 9 in the same cycle -> with RS_DISP_BYPASS_EN the entry issues the next cycle; without it the entry stays unissued. Then assert flush -> free_cnt=8 and iss_valid=0.
